// File: rtl/vga_sprite_module_if.sv
// Bus bundle between the VGA sync module / ROM side and the sprite overlay.
// The master drives pixel coordinates, window requests and ROM row data.
// The slave (the overlay) returns the ROM address, colour and status.
interface vga_sprite_module_if #(
    parameter int IMG_W   = 64,
    parameter int ADDR_W  = 6,
    parameter int COLOR_W = 1
);
    logic                       Ready_Sig;
    logic [10:0]                Column_Addr_Sig;
    logic [10:0]                Row_Addr_Sig;
    logic [10:0]                Pos_X_Sig;
    logic [10:0]                Pos_Y_Sig;
    logic [1:0]                 Scale_Sig;
    logic                       Mirror_Sig;
    logic                       Pos_Load_Sig;
    logic                       Pos_Busy_Sig;
    logic [IMG_W*COLOR_W-1:0]   Red_Rom_Data;
    logic [IMG_W*COLOR_W-1:0]   Green_Rom_Data;
    logic [IMG_W*COLOR_W-1:0]   Blue_Rom_Data;
    logic [ADDR_W-1:0]          Rom_Addr;
    logic [COLOR_W-1:0]         Red_Sig;
    logic [COLOR_W-1:0]         Green_Sig;
    logic [COLOR_W-1:0]         Blue_Sig;
    logic                       Hit_Sig;

    modport master (
        output Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, Pos_X_Sig, Pos_Y_Sig,
               Scale_Sig, Mirror_Sig, Pos_Load_Sig,
               Red_Rom_Data, Green_Rom_Data, Blue_Rom_Data,
        input  Pos_Busy_Sig, Rom_Addr, Red_Sig, Green_Sig, Blue_Sig, Hit_Sig
    );

    modport slave (
        input  Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, Pos_X_Sig, Pos_Y_Sig,
               Scale_Sig, Mirror_Sig, Pos_Load_Sig,
               Red_Rom_Data, Green_Rom_Data, Blue_Rom_Data,
        output Pos_Busy_Sig, Rom_Addr, Red_Sig, Green_Sig, Blue_Sig, Hit_Sig
    );
endinterface

// File: rtl/vga_sprite_module.sv
// Movable, scalable, mirrorable picture overlay for the VGA path.
// Pipeline: stage 1 (window test + ROM address), ROM_LAT-deep delay line
// matching the external ROM, then a registered colour/hit output stage.
// Total latency from coordinates to colour is ROM_LAT+2 cycles.
module vga_sprite_module #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int ADDR_W  = 6,
    parameter int COLOR_W = 1,
    parameter int ROM_LAT = 1
) (
    input  logic               CLK,
    input  logic               RST,
    vga_sprite_module_if.slave bus
);
    localparam int LX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int DW   = IMG_W * COLOR_W;
    localparam int BW   = (DW > 1) ? $clog2(DW) : 1;
    localparam int LAST = ROM_LAT - 1;

    logic        frame_start;
    logic        load;
    logic [1:0]  s_in;

    // Shadow (applied) and pending (captured) window parameters
    logic [10:0] x_q, y_q, px_q, py_q, x_d, y_d;
    logic [1:0]  s_q, ps_q, s_d;
    logic        m_q, pm_q, m_d;
    logic        busy_q;

    assign load        = bus.Pos_Load_Sig;
    assign frame_start = bus.Ready_Sig && (bus.Column_Addr_Sig == 11'd0)
                         && (bus.Row_Addr_Sig == 11'd0);
    // Scale codes 2 and 3 both mean a shift of 2 (4x)
    assign s_in = (bus.Scale_Sig == 2'd0) ? 2'd0 :
                  (bus.Scale_Sig == 2'd1) ? 2'd1 : 2'd2;

    // Effective window for this pixel: at frame start the new values apply
    // immediately, so the whole frame (including pixel 0,0) is consistent.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        s_d = s_q;
        m_d = m_q;
        if (frame_start) begin
            if (load) begin
                x_d = bus.Pos_X_Sig;
                y_d = bus.Pos_Y_Sig;
                s_d = s_in;
                m_d = bus.Mirror_Sig;
            end else begin
                x_d = px_q;
                y_d = py_q;
                s_d = ps_q;
                m_d = pm_q;
            end
        end
    end

    // Capture requests into pending, transfer to shadows at frame start
    always_ff @(posedge CLK) begin
        if (RST) begin
            x_q    <= '0;
            y_q    <= '0;
            s_q    <= '0;
            m_q    <= 1'b0;
            px_q   <= '0;
            py_q   <= '0;
            ps_q   <= '0;
            pm_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            if (load) begin
                px_q <= bus.Pos_X_Sig;
                py_q <= bus.Pos_Y_Sig;
                ps_q <= s_in;
                pm_q <= bus.Mirror_Sig;
            end
            if (frame_start) begin
                x_q    <= x_d;
                y_q    <= y_d;
                s_q    <= s_d;
                m_q    <= m_d;
                busy_q <= 1'b0;
            end else if (load) begin
                busy_q <= 1'b1;
            end
        end
    end

    // Window test in 13-bit arithmetic so windows past 2047 clip, never wrap
    logic [12:0]        col_w, row_w, x_w, y_w, dx, dy, w_lim, h_lim;
    logic               inside_d;
    logic [LX_W-1:0]    lx_raw, lx_d;
    logic [ADDR_W-1:0]  ly_d;

    // Local image coordinates for the current pixel
    always_comb begin
        col_w    = {2'b00, bus.Column_Addr_Sig};
        row_w    = {2'b00, bus.Row_Addr_Sig};
        x_w      = {2'b00, x_d};
        y_w      = {2'b00, y_d};
        dx       = col_w - x_w;
        dy       = row_w - y_w;
        w_lim    = 13'(IMG_W) << s_d;
        h_lim    = 13'(IMG_H) << s_d;
        inside_d = bus.Ready_Sig && (col_w >= x_w) && (row_w >= y_w)
                   && (dx < w_lim) && (dy < h_lim);
        lx_raw   = LX_W'(dx >> s_d);
        lx_d     = m_d ? (LX_W'(IMG_W - 1) - lx_raw) : lx_raw;
        ly_d     = inside_d ? ADDR_W'(dy >> s_d) : '0;
    end

    logic              in_s1_q;
    logic [LX_W-1:0]   lx_s1_q;
    logic [ADDR_W-1:0] rom_addr_q;

    // Stage 1: register window flag, column index and ROM row address
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_s1_q    <= 1'b0;
            lx_s1_q    <= '0;
            rom_addr_q <= '0;
        end else begin
            in_s1_q    <= inside_d;
            lx_s1_q    <= lx_d;
            rom_addr_q <= ly_d;
        end
    end

    logic            in_dl_q [ROM_LAT];
    logic [LX_W-1:0] lx_dl_q [ROM_LAT];

    // Delay line keeping flag and column aligned with the ROM read latency
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                in_dl_q[i] <= 1'b0;
                lx_dl_q[i] <= '0;
            end
        end else begin
            in_dl_q[0] <= in_s1_q;
            lx_dl_q[0] <= lx_s1_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                in_dl_q[i] <= in_dl_q[i-1];
                lx_dl_q[i] <= lx_dl_q[i-1];
            end
        end
    end

    // Pixel 0 sits in the MSB group of each ROM row
    logic [BW-1:0]      pix_base;
    logic [DW-1:0]      rom_data [3];
    logic [COLOR_W-1:0] chan_out [3];
    logic               hit_q;

    assign pix_base    = BW'((IMG_W - 1 - int'(lx_dl_q[LAST])) * COLOR_W);
    assign rom_data[0] = bus.Red_Rom_Data;
    assign rom_data[1] = bus.Green_Rom_Data;
    assign rom_data[2] = bus.Blue_Rom_Data;

    // Output stage: hit flag registered alongside the colours
    always_ff @(posedge CLK) begin
        if (RST) hit_q <= 1'b0;
        else     hit_q <= in_dl_q[LAST];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [COLOR_W-1:0] chan_q;
            // Per-channel colour register, blanked outside the window
            always_ff @(posedge CLK) begin
                if (RST)                 chan_q <= '0;
                else if (in_dl_q[LAST])  chan_q <= rom_data[gi][pix_base +: COLOR_W];
                else                     chan_q <= '0;
            end
            assign chan_out[gi] = chan_q;
        end
    endgenerate

    assign bus.Rom_Addr     = rom_addr_q;
    assign bus.Pos_Busy_Sig = busy_q;
    assign bus.Hit_Sig      = hit_q;
    assign bus.Red_Sig      = chan_out[0];
    assign bus.Green_Sig    = chan_out[1];
    assign bus.Blue_Sig     = chan_out[2];
endmodule

// File: tb/tb_vga_sprite_module.sv
// Directed bench for vga_sprite_module: ROM with red/green on the diagonal
// and blue on diagonal plus anti-diagonal; pixels streamed one per cycle,
// each expected {hit,r,g,b} checked ROM_LAT+2 cycles later.
module tb_vga_sprite_module;
    localparam int IMG_W   = 64;
    localparam int IMG_H   = 64;
    localparam int ADDR_W  = 6;
    localparam int COLOR_W = 1;
    localparam int ROM_LAT = 1;
    localparam int LAT     = ROM_LAT + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sprite_module_if #(.IMG_W(IMG_W), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus();

    vga_sprite_module #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
        .COLOR_W(COLOR_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // External ROM model, one cycle read latency
    logic [63:0] rom_rg [IMG_H];
    logic [63:0] rom_b  [IMG_H];
    always @(posedge clk) begin
        bus.Red_Rom_Data   <= rom_rg[bus.Rom_Addr];
        bus.Green_Rom_Data <= rom_rg[bus.Rom_Addr];
        bus.Blue_Rom_Data  <= rom_b[bus.Rom_Addr];
    end

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        bit       chk;
        logic [3:0] exp;
        int       tag;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic        rdy;
        logic [10:0] col;
        logic [10:0] row;
        logic [3:0]  exp;
    } vec_t;
    vec_t tbl [12];

    logic [10:0] ld_x = '0, ld_y = '0;
    logic [1:0]  ld_s = '0;
    logic        ld_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One pixel per call: check the pixel issued LAT cycles ago, then drive.
    task automatic drive(input bit r, input bit rdy, input int col, input int row,
                         input bit ld, input logic [3:0] exp, input int tag);
        exp_t e;
        @(negedge clk);
        if (q.size() >= LAT) begin
            e = q.pop_front();
            if (e.chk)
                check($sformatf("pix%0d hit_rgb", e.tag),
                      {28'd0, bus.Hit_Sig, bus.Red_Sig, bus.Green_Sig, bus.Blue_Sig},
                      {28'd0, e.exp});
        end
        rst                 = r;
        bus.Ready_Sig       = rdy;
        bus.Column_Addr_Sig = 11'(col);
        bus.Row_Addr_Sig    = 11'(row);
        bus.Pos_Load_Sig    = ld;
        bus.Pos_X_Sig       = ld_x;
        bus.Pos_Y_Sig       = ld_y;
        bus.Scale_Sig       = ld_s;
        bus.Mirror_Sig      = ld_m;
        if (r) begin
            // everything in flight is flushed by the reset edge
            foreach (q[i]) begin
                q[i].chk = 1'b1;
                q[i].exp = 4'h0;
            end
            q.push_back('{1'b1, 4'h0, tag});
        end else begin
            q.push_back('{1'b1, exp, tag});
        end
        $display("pixel %0d rst=%0d rdy=%0d col=%0d row=%0d load=%0d", tag, r, rdy, col, row, ld);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < IMG_H; r++) begin
            rom_rg[r] = 64'd1 << (63 - r);
            rom_b[r]  = rom_rg[r] | (64'd1 << r);
        end
        tbl[0]  = '{1'b1, 11'd0,    11'd0,    4'hF};
        tbl[1]  = '{1'b1, 11'd1,    11'd1,    4'hF};
        tbl[2]  = '{1'b1, 11'd1,    11'd0,    4'h8};
        tbl[3]  = '{1'b1, 11'd63,   11'd0,    4'h9};
        tbl[4]  = '{1'b1, 11'd63,   11'd63,   4'hF};
        tbl[5]  = '{1'b1, 11'd0,    11'd63,   4'h9};
        tbl[6]  = '{1'b1, 11'd64,   11'd10,   4'h0};
        tbl[7]  = '{1'b1, 11'd10,   11'd64,   4'h0};
        tbl[8]  = '{1'b1, 11'd32,   11'd32,   4'hF};
        tbl[9]  = '{1'b0, 11'd32,   11'd32,   4'h0};
        tbl[10] = '{1'b1, 11'd31,   11'd32,   4'h9};
        tbl[11] = '{1'b1, 11'd2047, 11'd2047, 4'h0};

        bus.Ready_Sig = 1'b0; bus.Column_Addr_Sig = '0; bus.Row_Addr_Sig = '0;
        bus.Pos_X_Sig = '0; bus.Pos_Y_Sig = '0; bus.Scale_Sig = '0;
        bus.Mirror_Sig = 1'b0; bus.Pos_Load_Sig = 1'b0;

        // Reset, with a load strobe during reset that must be ignored
        ld_x = 11'd500; ld_y = 11'd500; ld_s = 2'd2; ld_m = 1'b1;
        drive(1, 1, 5, 5, 1, 4'h0, 900);
        drive(1, 1, 6, 6, 0, 4'h0, 901);
        drive(1, 1, 7, 7, 0, 4'h0, 902);
        drive(1, 1, 8, 8, 0, 4'h0, 903);
        check("reset Rom_Addr", 32'(bus.Rom_Addr), 0);
        check("reset Hit_Sig", 32'(bus.Hit_Sig), 0);
        check("reset Red_Sig", 32'(bus.Red_Sig), 0);
        check("reset Pos_Busy_Sig", 32'(bus.Pos_Busy_Sig), 0);

        // Default window at origin, 1x, table vectors
        for (int i = 0; i < 12; i++)
            drive(0, tbl[i].rdy, int'(tbl[i].col), int'(tbl[i].row), 0, tbl[i].exp, i);
        check("busy after reset load", 32'(bus.Pos_Busy_Sig), 0);

        // Mid-frame load X=100 Y=50 S=1: applied only from next frame start
        ld_x = 11'd100; ld_y = 11'd50; ld_s = 2'd1; ld_m = 1'b0;
        drive(0, 1, 5, 5, 1, 4'hF, 100);
        drive(0, 1, 101, 51, 0, 4'h0, 101);
        check("busy after load", 32'(bus.Pos_Busy_Sig), 1);
        drive(0, 1, 6, 6, 0, 4'hF, 102);
        drive(0, 1, 0, 0, 0, 4'h0, 103);
        drive(0, 1, 101, 51, 0, 4'hF, 104);
        check("busy after frame start", 32'(bus.Pos_Busy_Sig), 0);
        drive(0, 1, 100, 50, 0, 4'hF, 105);
        drive(0, 1, 227, 177, 0, 4'hF, 106);
        drive(0, 1, 228, 50, 0, 4'h0, 107);
        drive(0, 1, 99, 50, 0, 4'h0, 108);
        drive(0, 1, 227, 50, 0, 4'h9, 109);
        drive(0, 1, 100, 177, 0, 4'h9, 110);
        drive(0, 1, 104, 60, 0, 4'h8, 111);
        drive(0, 1, 5, 5, 0, 4'h0, 112);
        check("Rom_Addr scaled row", 32'(bus.Rom_Addr), 5);
        drive(0, 1, 227, 178, 0, 4'h0, 113);

        // Mirror at origin
        ld_x = 11'd0; ld_y = 11'd0; ld_s = 2'd0; ld_m = 1'b1;
        drive(0, 1, 300, 300, 1, 4'h0, 200);
        drive(0, 0, 0, 0, 0, 4'h0, 201);
        check("busy mirror load", 32'(bus.Pos_Busy_Sig), 1);
        drive(0, 1, 0, 0, 0, 4'h9, 202);
        drive(0, 1, 63, 0, 0, 4'hF, 203);
        drive(0, 1, 1, 0, 0, 4'h8, 204);
        drive(0, 1, 62, 1, 0, 4'hF, 205);
        drive(0, 1, 63, 1, 0, 4'h8, 206);

        // Overwritten load, then X=2000 with scale code 3 (4x), clipped at 2047
        ld_x = 11'd5; ld_y = 11'd0; ld_s = 2'd0; ld_m = 1'b0;
        drive(0, 1, 40, 40, 1, 4'h9, 300);
        ld_x = 11'd2000; ld_s = 2'd3;
        drive(0, 1, 41, 40, 1, 4'h8, 301);
        drive(0, 1, 0, 0, 0, 4'h0, 302);
        check("busy before apply", 32'(bus.Pos_Busy_Sig), 1);
        drive(0, 1, 2000, 0, 0, 4'hF, 303);
        check("busy after apply", 32'(bus.Pos_Busy_Sig), 0);
        drive(0, 1, 2047, 0, 0, 4'h8, 304);
        drive(0, 1, 2047, 44, 0, 4'hF, 305);
        drive(0, 1, 1999, 0, 0, 4'h0, 306);
        drive(0, 1, 5, 0, 0, 4'h0, 307);
        drive(0, 1, 2003, 3, 0, 4'hF, 308);
        drive(0, 1, 2004, 0, 0, 4'h8, 309);
        drive(0, 1, 2000, 255, 0, 4'h9, 310);
        drive(0, 1, 2000, 256, 0, 4'h0, 311);
        drive(0, 1, 0, 3, 0, 4'h0, 312);

        // Load coinciding with frame start: applies at once, busy stays 0
        ld_x = 11'd10; ld_y = 11'd0; ld_s = 2'd0; ld_m = 1'b0;
        drive(0, 1, 0, 0, 1, 4'h0, 400);
        drive(0, 1, 10, 0, 0, 4'hF, 401);
        check("busy load at frame start", 32'(bus.Pos_Busy_Sig), 0);
        drive(0, 1, 9, 0, 0, 4'h0, 402);
        drive(0, 1, 73, 0, 0, 4'h9, 403);
        drive(0, 1, 74, 0, 0, 4'h0, 404);

        // Reset mid-line while inside the window, with a pending load
        ld_x = 11'd700;
        drive(0, 1, 12, 2, 1, 4'hF, 500);
        drive(0, 1, 13, 3, 0, 4'hF, 501);
        drive(1, 1, 14, 4, 0, 4'h0, 502);
        drive(1, 1, 15, 5, 0, 4'h0, 503);
        check("midreset Hit_Sig", 32'(bus.Hit_Sig), 0);
        check("midreset Rom_Addr", 32'(bus.Rom_Addr), 0);
        check("midreset Pos_Busy_Sig", 32'(bus.Pos_Busy_Sig), 0);
        drive(0, 1, 3, 3, 0, 4'hF, 504);
        drive(0, 1, 70, 3, 0, 4'h0, 505);
        drive(0, 1, 0, 0, 0, 4'hF, 506);
        drive(0, 1, 5, 5, 0, 4'hF, 507);
        check("busy after reset", 32'(bus.Pos_Busy_Sig), 0);

        for (int i = 0; i < LAT; i++)
            drive(0, 0, 0, 0, 0, 4'h0, 600 + i);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
